mux_nx1_reg: RTL and testbench

Parametrised, registered N-channel, W-bit multiplexer with valid/ready handshaking on every input channel and on the output. It is the successor to the library's combinational 8-bit 4:1 mux. It adds:
- arbitrary width and channel count;
- a one-stage output register with backpressure;
- a round-robin scan mode that forwards whichever channels have data, in fair rotation.

It sits between several producer blocks and a single shared consumer.

---
 rtl/mux_nx1_reg.sv | 143 ++++++++++++++
 tb/tb_mux_nx1_reg.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/mux_nx1_reg.sv
// mux_nx1_reg: registered N-channel, W-bit multiplexer with valid/ready
// handshaking on every input channel and on the output. Several producers
// share one consumer. The output stage is one register and supports
// backpressure. When a consume and a new load happen in the same cycle,
// the new word replaces the old one with no bubble.
//
// Optional feature macro: MUX_RR_EN
//   defined   - round-robin scan mode (mode=1) and its rotation pointer
//   undefined - fixed select only, and the mode input is ignored
//
// Ports:
//   clk        clock, every state update happens on its rising edge
//   rst_n      synchronous active-low reset
//   in_data    CHANNELS*WIDTH flat bus, channel k at [k*WIDTH +: WIDTH]
//   in_valid   per-channel data valid
//   in_ready   per-channel accept (combinational, at most one bit high)
//   sel        channel chosen in fixed mode (values >= CHANNELS never grant)
//   mode       0 = fixed select, 1 = round-robin
//   out_data   registered data word
//   out_valid  out_data holds an unconsumed word
//   out_ready  consumer takes out_data this cycle
//   out_chan   index of the channel that supplied out_data
module mux_nx1_reg #(
    parameter  int WIDTH    = 8,
    parameter  int CHANNELS = 4,
    localparam int SEL_W    = $clog2(CHANNELS)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [CHANNELS*WIDTH-1:0] in_data,
    input  logic [CHANNELS-1:0]       in_valid,
    output logic [CHANNELS-1:0]       in_ready,
    input  logic [SEL_W-1:0]          sel,
    input  logic                      mode,
    output logic [WIDTH-1:0]          out_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [SEL_W-1:0]          out_chan
);

    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic             out_valid_q, out_valid_d;
    logic [SEL_W-1:0] out_chan_q, out_chan_d;

    logic             free;
    logic             gnt_vld;
    logic [SEL_W-1:0] gnt_idx;
    logic             xfer;

`ifdef MUX_RR_EN
    logic [SEL_W-1:0] ptr_q, ptr_d;
    logic [SEL_W-1:0] scan_idx;

    // Scan the channels starting at ptr and wrapping. The first valid
    // channel wins. ptr always stays below CHANNELS, so the modulo wraps
    // at most once.
    always_comb begin
        gnt_vld  = 1'b0;
        gnt_idx  = '0;
        scan_idx = '0;
        if (mode) begin
            for (int i = 0; i < CHANNELS; i++) begin
                scan_idx = SEL_W'((int'(ptr_q) + i) % CHANNELS);
                if (!gnt_vld && in_valid[scan_idx]) begin
                    gnt_vld = 1'b1;
                    gnt_idx = scan_idx;
                end
            end
        end else if (int'(sel) < CHANNELS) begin
            gnt_vld = in_valid[sel];
            gnt_idx = sel;
        end
    end
`else
    // Without the round-robin feature, mode has no effect.
    logic mode_unused;
    assign mode_unused = mode;

    always_comb begin
        gnt_vld = 1'b0;
        gnt_idx = '0;
        if (int'(sel) < CHANNELS) begin
            gnt_vld = in_valid[sel];
            gnt_idx = sel;
        end
    end
`endif

    // The output register can take a word when it is empty or is being
    // consumed this cycle. in_ready is held low while reset is asserted.
    assign free = !out_valid_q || out_ready;
    assign xfer = rst_n && gnt_vld && free;

    always_comb begin
        in_ready = '0;
        if (xfer) in_ready[gnt_idx] = 1'b1;
    end

    always_comb begin
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        out_chan_d  = out_chan_q;
        if (xfer) begin
            out_data_d  = in_data[gnt_idx*WIDTH +: WIDTH];
            out_chan_d  = gnt_idx;
            out_valid_d = 1'b1;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

`ifdef MUX_RR_EN
    // After a round-robin grant, the next scan starts at the channel just
    // after the one granted. In fixed mode the pointer keeps its value.
    always_comb begin
        ptr_d = ptr_q;
        if (xfer && mode)
            ptr_d = (int'(gnt_idx) == CHANNELS - 1) ? '0 : gnt_idx + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) ptr_q <= '0;
        else        ptr_q <= ptr_d;
    end
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_chan_q  <= '0;
        end else begin
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            out_chan_q  <= out_chan_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign out_chan  = out_chan_q;

endmodule

// File: tb/tb_mux_nx1_reg.sv
// Self-checking bench for mux_nx1_reg. It uses five channels, so the
// channel count is not a power of two and sel values 5..7 are out of range.
// Expected values come from a behavioural model of the handshake rules.
module tb_mux_nx1_reg;
    localparam int W = 8;
    localparam int C = 5;
    localparam int SW = $clog2(C);

    logic            clk = 1'b0;
    logic            rst_n;
    logic [C*W-1:0]  in_data;
    logic [C-1:0]    in_valid;
    logic [C-1:0]    in_ready;
    logic [SW-1:0]   sel;
    logic            mode;
    logic [W-1:0]    out_data;
    logic            out_valid;
    logic            out_ready;
    logic [SW-1:0]   out_chan;

    logic [W-1:0]    ch_data [C];

    always #5 clk = ~clk;

    always_comb begin
        in_data = '0;
        for (int k = 0; k < C; k++) in_data[k*W +: W] = ch_data[k];
    end

    mux_nx1_reg #(.WIDTH(W), .CHANNELS(C)) dut (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .sel(sel), .mode(mode), .out_data(out_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_chan(out_chan)
    );

    // Model state
    bit       m_valid;
    int       m_data;
    int       m_chan;
    int       m_ptr;
    int       checks   = 0;
    int       failures = 0;

`ifdef MUX_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Grant from the rules. In round-robin mode, pick the lowest valid
    // channel at or above ptr. If there is none, wrap to the lowest valid
    // channel overall.
    function automatic void model_grant(output bit ok, output int g);
        int hi, lo;
        ok = 1'b0; g = 0;
        if (RR && mode) begin
            hi = -1; lo = -1;
            for (int k = 0; k < C; k++) if (in_valid[k]) begin
                if (k >= m_ptr && hi < 0) hi = k;
                if (lo < 0) lo = k;
            end
            ok = (lo >= 0);
            g  = (hi >= 0) ? hi : lo;
        end else if (int'(sel) < C && in_valid[sel]) begin
            ok = 1'b1; g = int'(sel);
        end
    endfunction

    // One clock: check in_ready before the edge, advance the model on the
    // edge, then check the registered outputs.
    task automatic cycle();
        bit ok; int g; bit fr;
        logic [C-1:0] er;
        #1;
        model_grant(ok, g);
        fr = !m_valid || out_ready;
        er = '0;
        if (rst_n && ok && fr) er[g] = 1'b1;
        chk("in_ready", 64'(in_ready), 64'(er));
        @(posedge clk);
        if (!rst_n) begin
            m_valid = 0; m_data = 0; m_chan = 0; m_ptr = 0;
        end else if (ok && fr) begin
            m_valid = 1; m_data = int'(ch_data[g]); m_chan = g;
            if (RR && mode) m_ptr = (g + 1) % C;
        end else if (out_ready) begin
            m_valid = 0;
        end
        #1;
        chk("out_valid", 64'(out_valid), 64'(m_valid));
        chk("out_data",  64'(out_data),  64'(m_data));
        chk("out_chan",  64'(out_chan),  64'(m_chan));
    endtask

    initial begin
        m_valid = 0; m_data = 0; m_chan = 0; m_ptr = 0;
        rst_n = 0; in_valid = '0; sel = '0; mode = 0; out_ready = 0;
        ch_data[0] = 8'h00; ch_data[1] = 8'hFF; ch_data[2] = 8'hAA;
        ch_data[3] = 8'h55; ch_data[4] = 8'h3C;

        // Reset state, with in_ready held low during reset even while inputs are valid
        cycle(); cycle();
        in_valid = '1;
        cycle();
        chk("rst_out_data", 64'(out_data), 64'h00);
        rst_n = 1;

        // Fixed select, stepping through channels 0..3 with out_ready high
        out_ready = 1;
        for (int s = 0; s < 4; s++) begin
            sel = SW'(s);
            cycle();
        end
        chk("fixed_last_data", 64'(out_data), 64'h55);
        chk("fixed_last_chan", 64'(out_chan), 64'd3);

        // Backpressure: load AA from ch2, then stall for three cycles
        sel = 3'd2; cycle();
        out_ready = 0;
        repeat (3) cycle();
        chk("stall_data", 64'(out_data), 64'hAA);
        sel = 3'd4; out_ready = 1; cycle();
        chk("after_stall_data", 64'(out_data), 64'h3C);

        // Selected channel is not valid, so the held word drains
        in_valid = 5'b11101; sel = 3'd1; cycle(); cycle();
        // Out-of-range sel never grants; sel=4 (the last channel) does
        in_valid = '1;
        sel = 3'd5; cycle();
        sel = 3'd7; cycle();
        sel = 3'd4; cycle();

        // Round robin with ch0, ch2 and ch3 valid, then with ch2 dropped.
        // Without the feature the same stimulus acts as fixed select on sel=2.
        mode = 1; sel = 3'd2; in_valid = 5'b01101;
        repeat (6) cycle();
        in_valid = 5'b01001;
        repeat (4) cycle();

        // Reset while a word is stalled, then check that round robin restarts at ch0
        in_valid = 5'b00100; cycle();
        out_ready = 0; cycle();
        rst_n = 0; cycle();
        chk("rst_stall_valid", 64'(out_valid), 64'd0);
        rst_n = 1; out_ready = 1; in_valid = 5'b11111; sel = 3'd3;
        cycle(); cycle();

        // Randomized traffic with occasional resets
        for (int n = 0; n < 400; n++) begin
            in_valid  = C'($urandom);
            sel       = SW'($urandom_range(0, 7));
            mode      = 1'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            rst_n     = ($urandom_range(0, 49) != 0);
            for (int k = 0; k < C; k++) ch_data[k] = W'($urandom);
            cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
